// File: rtl/pt_rd_arbiter_pkg.sv
// Shared constants and tag type for the page-table read arbiter.
// Used by pt_rd_arbiter and its round-robin sub-block.
package pt_rd_arbiter_pkg;

  localparam int PT_RD_LATENCY = 2;
  localparam int VIRT_ADDR_W   = 58;
  localparam int PHY_ADDR_W    = 32;
  localparam int TAG_ID_W      = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/pt_rd_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr.
// Returns a one-hot grant, the encoded winner and a found flag.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] win,
  output logic         any
);

  logic [W-1:0] idx;

  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(ptr) + k) % N);
      if (en && !any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end
  end

endmodule

// File: rtl/pt_rd_arbiter.sv
// Round-robin share of the page-table read-translation port.
// Optional PT_RD_ARB_PERF_EN adds stall_cnt / xfer_cnt counters.
module pt_rd_arbiter
  import pt_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int PT_LAT  = PT_RD_LATENCY
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*VIRT_ADDR_W-1:0] req_vaddr,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [PHY_ADDR_W-1:0]          rsp_paddr,
  output logic [VIRT_ADDR_W-1:0]         afu_virt_rd_addr,
  output logic                           pt_re_rd,
  input  logic [PHY_ADDR_W-1:0]          afu_phy_rd_addr,
  input  logic                           afu_phy_rd_addr_valid,
  input  logic [1:0]                     pt_status,
  output logic                           arb_idle,
  output logic                           lat_err
`ifdef PT_RD_ARB_PERF_EN
  ,
  output logic [31:0]                    stall_cnt,
  output logic [31:0]                    xfer_cnt
`endif
);

  logic [VIRT_ADDR_W-1:0] va [NUM_REQ];
  logic [ID_W-1:0]        ptr;
  logic [ID_W-1:0]        win;
  logic [ID_W-1:0]        iss_id;
  logic                   any;
  logic                   xfer;
  tag_t                   tags [PT_LAT];
  tag_t                   last;
  logic                   unused;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_va
    assign va[i] = req_vaddr[VIRT_ADDR_W*i +: VIRT_ADDR_W];
  end

  rr_arbiter #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_rr (
    .req (req_valid),
    .en  (pt_status[0]),
    .ptr (ptr),
    .gnt (req_ready),
    .win (win),
    .any (any)
  );

  assign xfer = any;
  assign last = tags[PT_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr              <= ID_W'(NUM_REQ-1);
      pt_re_rd         <= 1'b0;
      afu_virt_rd_addr <= '0;
      iss_id           <= '0;
    end else begin
      pt_re_rd <= xfer;
      if (xfer) begin
        ptr              <= win;
        afu_virt_rd_addr <= va[win];
        iss_id           <= win;
      end
    end
  end

  // Fixed-length shift: tags line up with translator latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PT_LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: pt_re_rd, id: TAG_ID_W'(iss_id)};
      for (int i = 1; i < PT_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lat_err <= 1'b0;
    else if (afu_phy_rd_addr_valid != last.valid)
      lat_err <= 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    rsp_paddr = '0;
    if (afu_phy_rd_addr_valid && last.valid) begin
      rsp_valid[last.id[ID_W-1:0]] = 1'b1;
      rsp_paddr = afu_phy_rd_addr;
    end
  end

  always_comb begin
    arb_idle = !pt_re_rd;
    for (int i = 0; i < PT_LAT; i++)
      if (tags[i].valid) arb_idle = 1'b0;
  end

  assign unused = ^{pt_status[1], last.id};

`ifdef PT_RD_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (|req_valid && !xfer && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (xfer && xfer_cnt != '1)
        xfer_cnt <= xfer_cnt + 32'd1;
    end
  end
`endif

endmodule
